// File: rtl/uart_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_array
// Brief    : UART datapath register-file memory. It has a registered read with a
//            valid strobe, a one-word-per-cycle clear sweep and address range
//            checking. Define UART_MEM_BYPASS_EN to get write-first forwarding
//            when a read and a write hit the same address in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module uart_mem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              addr_err,
    input  logic              clr,
    output logic              busy
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                addr_err_q, addr_err_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_waddr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic                w_wr_in_range;
    logic                w_rd_in_range;

    // DEPTH need not be a power of two, so compare in a wide domain.
    assign w_wr_in_range = (32'(wr_addr) < 32'(DEPTH));
    assign w_rd_in_range = (32'(rd_addr) < 32'(DEPTH));

    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        addr_err_d  = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_waddr = clr_ptr_q;
        w_mem_wdata = '0;

        case (state_q)
            ST_CLEAR: begin
                w_mem_we = 1'b1;
                if (clr_ptr_q == C_LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (wr_en) begin
                    if (w_wr_in_range) begin
                        w_mem_we    = 1'b1;
                        w_mem_waddr = wr_addr;
                        w_mem_wdata = wr_data;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
                if (rd_en) begin
                    rd_valid_d = 1'b1;
                    if (w_rd_in_range) begin
                        rd_data_d = mem_q[rd_addr];
`ifdef UART_MEM_BYPASS_EN
                        if (wr_en && (wr_addr == rd_addr)) begin
                            rd_data_d = wr_data;
                        end
`endif
                    end else begin
                        rd_data_d  = '0;
                        addr_err_d = 1'b1;
                    end
                end
                // Requests in the same cycle as clr are still served above.
                if (clr) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Storage is deliberately unreset; the sweep zeroes it after reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_mem_waddr] <= w_mem_wdata;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign addr_err = addr_err_q;
    assign busy     = (state_q == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_mem_array
// Brief    : Directed self-checking bench for uart_mem_array (16-word and
//            12-word instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mem_array;

    logic       clk;
    logic       rst;

    logic       wr_en, rd_en, clr;
    logic [3:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;
    logic       rd_valid, addr_err, busy;

    logic       wr_en12, rd_en12, clr12;
    logic [3:0] wr_addr12, rd_addr12;
    logic [7:0] wr_data12, rd_data12;
    logic       rd_valid12, addr_err12, busy12;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt;

    uart_mem_array #(.DATA_W(8), .DEPTH(16)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .addr_err (addr_err),
        .clr      (clr),
        .busy     (busy)
    );

    uart_mem_array #(.DATA_W(8), .DEPTH(12)) u_dut12 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en12),
        .wr_addr  (wr_addr12),
        .wr_data  (wr_data12),
        .rd_en    (rd_en12),
        .rd_addr  (rd_addr12),
        .rd_data  (rd_data12),
        .rd_valid (rd_valid12),
        .addr_err (addr_err12),
        .clr      (clr12),
        .busy     (busy12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with busy high, bounded so a stuck engine cannot hang the run.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 40) begin
            chk("busy_rd_valid", 32'(rd_valid), 32'd0);
            chk("busy_addr_err", 32'(addr_err), 32'd0);
            cnt++;
            step();
        end
    endtask

    task automatic wr16(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd16(input logic [3:0] a);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        wr_en12 = 1'b0; rd_en12 = 1'b0; clr12 = 1'b0;
        wr_addr12 = '0; rd_addr12 = '0; wr_data12 = '0;

        // Reset then clear sweep
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        rst = 1'b1;
        count_busy(busy_cnt);
        chk("init_sweep_len", 32'(busy_cnt), 32'd16);
        for (int a = 0; a < 16; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a);
            step();
            chk("init_rd_valid", 32'(rd_valid), 32'd1);
            chk("init_rd_data", 32'(rd_data), 32'd0);
        end
        rd_en = 1'b0;

        // Write then read
        wr16(4'd3, 8'hA5);
        rd16(4'd3);
        chk("wr_rd_data", 32'(rd_data), 32'hA5);
        chk("wr_rd_valid", 32'(rd_valid), 32'd1);
        step();
        chk("hold_rd_valid", 32'(rd_valid), 32'd0);
        chk("hold_rd_data", 32'(rd_data), 32'hA5);

        // Same-address collision
        wr16(4'd5, 8'h11);
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h22;
        rd_en = 1'b1; rd_addr = 4'd5;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
`ifdef UART_MEM_BYPASS_EN
        chk("collide_rd_data", 32'(rd_data), 32'h22);
`else
        chk("collide_rd_data", 32'(rd_data), 32'h11);
`endif
        rd16(4'd5);
        chk("collide_after", 32'(rd_data), 32'h22);

        // Different-address simultaneous read and write
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h3C;
        rd_en = 1'b1; rd_addr = 4'd3;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("diff_rd_data", 32'(rd_data), 32'hA5);
        rd16(4'd7);
        chk("diff_wr_data", 32'(rd_data), 32'h3C);

        // Software clear with requests during busy
        for (int a = 0; a < 16; a++) wr16(4'(a), 8'hFF);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_busy", 32'(busy), 32'd1);
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h33;
        rd_en = 1'b1; rd_addr = 4'd2;
        count_busy(busy_cnt);
        wr_en = 1'b0; rd_en = 1'b0;
        chk("clr_sweep_len", 32'(busy_cnt), 32'd16);
        for (int a = 0; a < 16; a++) begin
            rd16(4'(a));
            chk("clr_rd_data", 32'(rd_data), 32'h00);
        end

        // Out-of-range on the 12-word instance
        for (int a = 0; a < 12; a++) begin
            wr_en12 = 1'b1; wr_addr12 = 4'(a); wr_data12 = 8'(8'h10 + a);
            step();
        end
        wr_en12 = 1'b1; wr_addr12 = 4'd13; wr_data12 = 8'h7E;
        step();
        wr_en12 = 1'b0;
        chk("oor_wr_err", 32'(addr_err12), 32'd1);
        rd_en12 = 1'b1; rd_addr12 = 4'd13;
        step();
        chk("oor_rd_err", 32'(addr_err12), 32'd1);
        chk("oor_rd_valid", 32'(rd_valid12), 32'd1);
        chk("oor_rd_data", 32'(rd_data12), 32'h00);
        for (int a = 0; a < 12; a++) begin
            rd_addr12 = 4'(a);
            step();
            chk("oor_word", 32'(rd_data12), 32'(8'h10 + a));
            chk("oor_no_err", 32'(addr_err12), 32'd0);
        end
        rd_en12 = 1'b0;

        // Reset mid-clear
        wr16(4'd1, 8'h5A);
        rd16(4'd1);
        chk("pre_rst_data", 32'(rd_data), 32'h5A);
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (7) step();
        rst = 1'b0;
        #1;
        chk("midclr_busy", 32'(busy), 32'd1);
        chk("midclr_rd_valid", 32'(rd_valid), 32'd0);
        chk("midclr_rd_data", 32'(rd_data), 32'd0);
        repeat (2) step();
        rst = 1'b1;
        count_busy(busy_cnt);
        chk("midclr_sweep_len", 32'(busy_cnt), 32'd16);
        rd16(4'd1);
        chk("midclr_word", 32'(rd_data), 32'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
